// File: rtl/csa_pkg.sv
// Shared constants for the registered 3-operand carry-save adder.
// WIDTH default, derived result width and a width helper.
package csa_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int SUM_W     = WIDTH_DEF + 1;

    // Result width for a given operand width.
    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used by the CSA row and the final adder.
// Ports: a_i, b_i, cin_i -> sum_o, cout_o (majority).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/csa.sv
// Registered 3-operand carry-save adder with carry-increment final adder.
// Ports: a, b, c (WIDTH) -> s (WIDTH+1, registered), clk, rst (async high).
module csa
    import csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH:0]   s,
    input  logic             clk,
    input  logic             rst
);

    localparam int SW = sum_w(WIDTH);
    localparam int LO = SW / 2;
    localparam int HI = SW - LO;

    logic [WIDTH-1:0] ps;
    logic [SW-1:0]    pc;
    logic [SW-1:0]    x;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    s_q;

    // CSA row: one full adder per bit, carries shifted up one place.
    assign pc[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        full_adder u_fa (
            .a_i   (a[i]),
            .b_i   (b[i]),
            .cin_i (c[i]),
            .sum_o (ps[i]),
            .cout_o(pc[i+1])
        );
    end

    assign x = {1'b0, ps};

    // Low half: plain ripple-carry.
    logic [LO:0] lc;
    assign lc[0] = 1'b0;

    for (genvar k = 0; k < LO; k++) begin : g_lo
        full_adder u_fa (
            .a_i   (x[k]),
            .b_i   (pc[k]),
            .cin_i (lc[k]),
            .sum_o (sum_d[k]),
            .cout_o(lc[k+1])
        );
    end

    // Upper half: ripple with carry-in 0, in parallel with the low half.
    // The top bit's carry-out falls outside the result, so only its sum
    // bit is formed.
    logic [HI-1:0] u0;
    logic [HI-1:0] uc;
    logic [HI-1:0] t;
    logic [HI-1:0] uinc;

    assign uc[0] = 1'b0;

    for (genvar j = 0; j < HI; j++) begin : g_hi
        if (j < HI - 1) begin : g_fa
            full_adder u_fa (
                .a_i   (x[LO+j]),
                .b_i   (pc[LO+j]),
                .cin_i (uc[j]),
                .sum_o (u0[j]),
                .cout_o(uc[j+1])
            );
        end else begin : g_top
            assign u0[j] = x[LO+j] ^ pc[LO+j] ^ uc[j];
        end
    end

    // Incrementer on the upper partial sum: toggle bits up to the first 0.
    assign t[0] = 1'b1;

    for (genvar j = 0; j < HI - 1; j++) begin : g_inc
        assign t[j+1] = t[j] & u0[j];
    end

    assign uinc = u0 ^ t;

    // Low-half carry-out picks the incremented or plain upper half.
    assign sum_d[SW-1:LO] = lc[LO] ? uinc : u0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= sum_d;
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_csa.sv
// Directed self-checking bench for csa (WIDTH=4).
// Vectors carry hand-computed sums; random phase uses (a+b+c)&31.
module tb_csa;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [4:0] s;

    int n_run;
    int n_fail;

    csa #(.WIDTH(4)) dut (
        .a  (a),
        .b  (b),
        .c  (c),
        .s  (s),
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got,
                         input logic [4:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, check just after the next rising edge.
    task automatic apply(input string tag, input logic [3:0] va,
                         input logic [3:0] vb, input logic [3:0] vc,
                         input logic [4:0] exp);
        @(negedge clk);
        a = va;
        b = vb;
        c = vc;
        @(posedge clk);
        #1;
        check(tag, s, exp);
    endtask

    initial begin
        logic [5:0] full;
        n_run  = 0;
        n_fail = 0;
        rst = 1'b0;
        a = 4'd5;
        b = 4'd7;
        c = 4'd9;

        #2 rst = 1'b1;
        #1 check("rst_async", s, 5'd0);
        @(posedge clk);
        #1 check("rst_hold1", s, 5'd0);
        @(posedge clk);
        #1 check("rst_hold2", s, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_release", s, 5'd21);

        apply("basic", 4'd1, 4'd2, 4'd3, 5'd6);
        #2;
        a = 4'd9;
        b = 4'd9;
        c = 4'd9;
        #1 check("basic_hold", s, 5'd6);
        @(posedge clk);
        #1 check("basic_next", s, 5'd27);

        apply("wrap_45", 4'd15, 4'd15, 4'd15, 5'd13);
        apply("wrap_32", 4'd15, 4'd15, 4'd2, 5'd0);
        apply("max_31", 4'd15, 4'd15, 4'd1, 5'd31);
        apply("zero", 4'd0, 4'd0, 4'd0, 5'd0);
        apply("sel_24", 4'd8, 4'd8, 4'd8, 5'd24);
        apply("sel_21", 4'd7, 4'd7, 4'd7, 5'd21);
        apply("mix_19", 4'd3, 4'd12, 4'd4, 5'd19);

        for (int i = 0; i < 10; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [3:0] rc;
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rc   = 4'($urandom_range(0, 15));
            full = 6'(ra) + 6'(rb) + 6'(rc);
            apply($sformatf("rand%0d", i), ra, rb, rc, full[4:0]);
        end

        // Async reset pulse between edges drops the held sum.
        apply("pre_pulse", 4'd10, 4'd10, 4'd1, 5'd21);
        #2 rst = 1'b1;
        #1 check("pulse_async", s, 5'd0);
        #1 rst = 1'b0;
        #1 check("pulse_held", s, 5'd0);
        @(posedge clk);
        #1 check("pulse_reload", s, 5'd21);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
